// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment codes are active-low in {a,b,c,d,e,f,g} order.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    // Number of decimal digits needed to hold the largest BIN_W-bit value.
    function automatic int bcd_digits(input int bin_w);
        longint max_v;
        int     n;
        max_v = (longint'(1) << bin_w) - 1;
        n     = 1;
        while (max_v >= 10) begin
            max_v = max_v / 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock
// followed by a single DONE cycle in which bcd_o is presented as the result.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter  int BIN_W = 13,
    localparam int BCD_N = bcd_digits(BIN_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [BIN_W-1:0]   bin_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [4*BCD_N-1:0] bcd_o,
    output conv_state_e        state_o
);

    // Handshake: start_i is accepted only on an edge where busy_o=0 (otherwise
    // dropped); busy_o then stays high for BIN_W+1 cycles and done_o is high in
    // the last of them, the one cycle in which bcd_o holds the final result.
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e        state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [4*BCD_N-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[4*BCD_N-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q != CONV_IDLE);
    assign done_o  = (state_q == CONV_DONE);
    assign bcd_o   = bcd_q;
    assign state_o = state_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment driver: latches a binary value, converts it to BCD,
// and scans the committed digits left to right with optional leading-zero blanking.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BIN_W     = 13,
    parameter int REFRESH_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  num_in,
    input  logic              num_valid,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int BCD_N = bcd_digits(BIN_W);
    localparam int EXT_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LEFT_IDX = IDX_W'(DIGITS - 1);

    logic [4*BCD_N-1:0] conv_bcd;
    logic [4*EXT_N-1:0] bcd_ext;
    logic               conv_busy, conv_done;
    conv_state_e        conv_state_unused;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (num_valid),
        .bin_i   (num_in),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .state_o (conv_state_unused)
    );

    logic [3:0]           digit_q [DIGITS];
    logic [3:0]           digit_d [DIGITS];
    logic                 ovf_q, ovf_d;
    logic [REFRESH_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0]    anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [DIGITS-1:0]    lead_zero;
    logic                 zero_run;
    logic [3:0]           cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Digits above DIGITS-1 only exist to detect values the display cannot show.
    always_comb begin
        bcd_ext = (4*EXT_N)'(conv_bcd);
        digit_d = digit_q;
        ovf_d   = ovf_q;
        if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_d[i] = bcd_ext[4*i +: 4];
            end
            ovf_d = 1'b0;
            for (int i = DIGITS; i < EXT_N; i++) begin
                if (bcd_ext[4*i +: 4] != 4'd0) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        presc_d = presc_q + REFRESH_W'(1);
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == '0) ? LEFT_IDX : idx_q - IDX_W'(1);
        end
    end

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (digit_q[i] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    always_comb begin
        cur_digit = digit_q[idx_q];
        anode_d   = ~(DIGITS'(1) << idx_q);
        dp_d      = ~dp_in[idx_q];
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank_lz && (idx_q != '0) && lead_zero[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= 4'd0;
            end
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= LEFT_IDX;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            digit_q <= digit_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign busy  = conv_busy;
    assign ovf   = ovf_q;
    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter BIN_W, default 13, width of the binary input (4..27).
REQ-003 Parameter REFRESH_W, default 18; each digit is active for 2^REFRESH_W clocks.
REQ-004 clk  in  1  system clock; one clock domain; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 num_in  in  BIN_W  unsigned binary value to display.
REQ-007 num_valid  in  1  load strobe; sampled only when busy=0.
REQ-008 blank_lz  in  1  1 = blank leading zeros.
REQ-009 dp_in  in  DIGITS  decimal point request per digit; bit DIGITS-1 = leftmost digit.
REQ-010 busy  out  1  conversion in progress.
REQ-011 ovf  out  1  latched value exceeds 10^DIGITS-1.
REQ-012 anode  out  DIGITS  active-low digit enable, one-hot-low; MSB = leftmost digit.
REQ-013 seg  out  7  active-low segments, order {a,b,c,d,e,f,g}; "0"=0000001, "1"=1001111.
REQ-014 dp  out  1  active-low decimal point for the active digit.

Function
REQ-015 When idle (busy=0), num_valid=1 SHALL capture num_in at that edge and set busy=1 on the next cycle.
REQ-016 Conversion SHALL be iterative shift-add-3 (double dabble), one bit per clock: BIN_W clocks, then 1 commit clock.
- busy is high for exactly BIN_W+1 cycles.
REQ-017 num_valid SHALL be ignored while busy=1; no queuing.
REQ-018 On the commit clock the displayed digit registers and ovf SHALL update together, and busy SHALL fall.
- Between commits the display shows the previous committed value, never a partial result.
REQ-019 The internal BCD width SHALL cover every BIN_W value.
- Any nonzero BCD digit above position DIGITS-1 sets ovf=1.
- While ovf=1, every digit shows a dash, 1111110.
REQ-020 A prescaler SHALL count 0..2^REFRESH_W-1.
- On wrap, the digit index advances from leftmost to rightmost.
- After the rightmost digit the index wraps back to the leftmost; non-power-of-2 DIGITS has no dead slots.
REQ-021 anode, seg and dp SHALL be registered.
- They reflect the current digit index and committed digits, one clock after an index change.
REQ-022 When blank_lz=1, zero digits to the left of the first nonzero digit SHALL show seg=1111111.
- The rightmost digit is never blanked.
- Blanking is not applied when ovf=1.
REQ-023 dp SHALL equal ~dp_in[index] for the active digit, independent of blanking.
REQ-024 BCD values 10..15 cannot occur; the decoder default SHALL output 1111111.

Reset
REQ-025 On rst=1 at a clock edge:
- busy=0, ovf=0, committed digits=0, prescaler=0, index=leftmost.
- anode all 1s, seg=1111111, dp=1.
REQ-026 rst during a conversion SHALL abort it; the committed display stays 0 and no late commit occurs.
REQ-027 A num_valid in the same cycle as rst SHALL be ignored.

Structure
REQ-028 Package seven_seg_pkg SHALL hold:
- the segment constants (digits 0-9, BLANK=1111111, DASH=1111110);
- a constant function returning the number of BCD digits for a given BIN_W.
REQ-029 Conversion SHALL live in sub-module bin2bcd_seq (start/busy/done handshake, parameter BIN_W).
- Scan, blanking and the segment decode stay in the top level.

Verification (bench: REFRESH_W=2 unless stated)
REQ-030 num_in=1234, num_valid pulse -> busy high for 14 cycles; then scan shows anode 0111/1001111, 1011/0010010, 1101/0000110, 1110/1001100.
REQ-031 blank_lz=1, num_in=7 -> anodes 0111, 1011, 1101 show 1111111; anode 1110 shows 0001111; blank_lz=0 -> the first three show 0000001.
REQ-032 DIGITS=3, BIN_W=10, num_in=1000 -> ovf=1 and all digits 1111110; then num_in=999 -> ovf=0 and digits 9,9,9; index sequence 2,1,0,2 with no gap.
REQ-033 Load 42, then pulse num_valid with 99 while busy -> display 42 with no second conversion.
REQ-034 Load 5555, then assert rst at cycle 6 of the conversion -> no commit; all outputs at reset values next cycle; scan resumes showing 0000.
REQ-035 dp_in=0100 with 1234 -> dp=0 only while anode=1011.
